// File: rtl/button_reader.sv
// Debounced button/switch reader: per-bit 2-flop synchronizer, debounce counter,
// registered one-cycle press/release strobes.
module button_reader #(
  parameter int unsigned Width   = 4,
  parameter int unsigned Limit   = 16,
  parameter int unsigned CntSize = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] buttons_i,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] press_o,
  output logic [Width-1:0] release_o,
  output logic             any_o
);

  localparam logic [CntSize-1:0] LastCnt = CntSize'(Limit - 1);

  logic [Width-1:0]   sync1_q, sync2_q;
  logic [Width-1:0]   level_q, level_d;
  logic [Width-1:0]   press_q, press_d;
  logic [Width-1:0]   release_q, release_d;
  logic               any_q, any_d;
  logic [CntSize-1:0] cnt_q [Width];
  logic [CntSize-1:0] cnt_d [Width];

  // Any single matching cycle clears the count: no partial credit for bouncy input.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int k = 0; k < Width; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != level_q[k]) begin
        if (cnt_q[k] == LastCnt) begin
          level_d[k]   = sync2_q[k];
          press_d[k]   = sync2_q[k];
          release_d[k] = ~sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CntSize'(1);
        end
      end
    end
    any_d = |(press_d | release_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int k = 0; k < Width; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q   <= buttons_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      for (int k = 0; k < Width; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign any_o     = any_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader: Limit=4 main instance plus a Limit=1 instance.
module tb_button_reader;

  logic       clock;
  logic       reset;
  logic [3:0] buttons;
  logic [3:0] level, press, rel;
  logic       any;
  logic [3:0] btn1;
  logic [3:0] level1, press1, rel1;
  logic       any1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  button_reader #(.Width(4), .Limit(4), .CntSize(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .buttons_i (buttons),
    .level_o   (level),
    .press_o   (press),
    .release_o (rel),
    .any_o     (any)
  );

  button_reader #(.Width(4), .Limit(1), .CntSize(16)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .buttons_i (btn1),
    .level_o   (level1),
    .press_o   (press1),
    .release_o (rel1),
    .any_o     (any1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n edges; sample 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [3:0] acc_p, acc_r;

  initial begin
    reset   = 1'b1;
    buttons = 4'hF;
    btn1    = 4'h0;

    // 1: reset with inputs high, then release
    tick(3);
    check("rst_level", level, 4'h0);
    check("rst_press", press, 4'h0);
    check("rst_release", rel, 4'h0);
    check("rst_any", any, 1'b0);
    reset = 1'b0;
    tick(5);
    check("rel_level_e5", level, 4'h0);
    check("rel_press_e5", press, 4'h0);
    tick(1);
    check("rel_level_e6", level, 4'hF);
    check("rel_press_e6", press, 4'hF);
    check("rel_any_e6", any, 1'b1);
    tick(1);
    check("rel_press_e7", press, 4'h0);
    check("rel_level_e7", level, 4'hF);

    // Return to all-released
    buttons = 4'h0;
    tick(8);
    check("clear_level", level, 4'h0);

    // 2: clean press on bit 0
    buttons = 4'b0001;
    tick(5);
    check("press_level_e4", level, 4'h0);
    check("press_strobe_e4", press, 4'h0);
    tick(1);
    check("press_level_e5", level, 4'b0001);
    check("press_strobe_e5", press, 4'b0001);
    check("press_any_e5", any, 1'b1);
    check("press_rel_e5", rel, 4'h0);
    acc_p = '0;
    acc_r = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      acc_p |= press;
      acc_r |= rel;
    end
    check("held_no_repeat", acc_p, 4'h0);
    check("held_no_release", acc_r, 4'h0);

    // 3: bounce on bit 1 (1,0,1,1,0) then final rise held
    begin
      logic [4:0] seq;
      seq = 5'b01101;  // applied LSB first: 1,0,1,1,0
      acc_p = '0;
      acc_r = '0;
      for (int i = 0; i < 5; i++) begin
        buttons[1] = seq[i];
        tick(1);
        acc_p |= press;
        acc_r |= rel;
      end
      buttons[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick(1);
        acc_p |= press;
        acc_r |= rel;
      end
      check("bounce_no_press", acc_p, 4'h0);
      check("bounce_no_release", acc_r, 4'h0);
      tick(1);
      check("bounce_press", press, 4'b0010);
      check("bounce_level", level, 4'b0011);
    end

    // 4: 3-cycle glitch on bit 2
    acc_p = '0;
    acc_r = '0;
    buttons[2] = 1'b1;
    tick(3);
    buttons[2] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      acc_p |= press | level;
      acc_r |= rel;
    end
    check("glitch_press_or_level", acc_p & 4'b0100, 4'h0);
    check("glitch_release", acc_r, 4'h0);
    check("glitch_level", level, 4'b0011);

    // 5: simultaneous swap 0011 -> 1100
    buttons = 4'b1100;
    tick(5);
    check("swap_press_e4", press, 4'h0);
    check("swap_rel_e4", rel, 4'h0);
    tick(1);
    check("swap_press", press, 4'b1100);
    check("swap_rel", rel, 4'b0011);
    check("swap_level", level, 4'b1100);
    check("swap_any", any, 1'b1);
    tick(1);
    check("swap_press_after", press, 4'h0);
    check("swap_rel_after", rel, 4'h0);
    check("swap_any_after", any, 1'b0);

    buttons = 4'h0;
    tick(8);
    check("clear2_level", level, 4'h0);

    // 6: reset mid-count on bit 3; Limit=1 instance sees a held input across reset
    buttons = 4'b1000;
    acc_p = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      acc_p |= press;
    end
    check("midcnt_no_press", acc_p, 4'h0);
    reset = 1'b1;
    btn1  = 4'b0001;
    tick(1);
    reset = 1'b0;
    check("midcnt_rst_level", level, 4'h0);
    tick(2);
    check("l1_rst_level_e2", level1, 4'h0);
    tick(1);
    check("l1_rst_level_e3", level1, 4'b0001);
    check("l1_rst_press_e3", press1, 4'b0001);
    tick(2);
    check("midcnt_level_e5", level, 4'h0);
    tick(1);
    check("midcnt_level_e6", level, 4'b1000);
    check("midcnt_press_e6", press, 4'b1000);

    // Limit=1 clean press latency
    btn1[1] = 1'b1;
    tick(2);
    check("l1_level_e1", level1, 4'b0001);
    tick(1);
    check("l1_press_e2", press1, 4'b0010);
    check("l1_level_e2", level1, 4'b0011);
    check("l1_any_e2", any1, 1'b1);
    tick(1);
    check("l1_press_e3", press1, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
